// File: rtl/midi_note_source_if.sv
// MIDI byte stream in, voice note state out.
interface midi_note_source_if;
  logic       midi_valid;
  logic [7:0] midi_byte;
  logic       note_on;
  logic       note_repeat;
  logic [6:0] note_start;
  logic [6:0] velocity;

  modport master (
    output midi_valid, midi_byte,
    input  note_on, note_repeat, note_start, velocity
  );
  modport slave (
    input  midi_valid, midi_byte,
    output note_on, note_repeat, note_start, velocity
  );
endinterface

// File: rtl/midi_note_source.sv
// Single MIDI voice: running-status parser feeding a 4-deep last-note-priority stack.
module midi_note_source (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [3:0]         channel,
  midi_note_source_if.slave  bus
);
  typedef enum logic [1:0] {NO_STATUS, WAIT_D1, WAIT_D2} pstate_t;

  pstate_t          state, state_nx;
  logic [7:0]       status, status_nx;
  logic [6:0]       d1, d1_nx;
  logic             msg_done;
  logic [7:0]       b;

  logic [3:0][6:0]  stk, rem, base, push;
  logic [2:0]       cnt;
  logic [1:0]       idx;
  logic             found;
  logic             hit, is_on, is_off, is_ano;
  logic             note_repeat_q;
  logic [6:0]       note_start_q, velocity_q;

  assign b = bus.midi_byte;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= NO_STATUS;
      status <= '0;
      d1     <= '0;
    end else begin
      state  <= state_nx;
      status <= status_nx;
      d1     <= d1_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    status_nx = status;
    d1_nx     = d1;
    msg_done  = 1'b0;
    if (en && bus.midi_valid) begin
      if (b[7]) begin
        if (b[7:3] == 5'b11111) begin
          // realtime: transparent to the parser
        end else if (b[7:4] == 4'hF) begin
          state_nx = NO_STATUS;
        end else begin
          status_nx = b;
          state_nx  = WAIT_D1;
        end
      end else begin
        case (state)
          WAIT_D1: begin
            if (status[7:5] == 3'b110) msg_done = 1'b1;
            else begin
              d1_nx    = b[6:0];
              state_nx = WAIT_D2;
            end
          end
          WAIT_D2: begin
            msg_done = 1'b1;
            state_nx = WAIT_D1;
          end
          default: ;
        endcase
      end
    end
  end

  assign hit    = msg_done && (status[3:0] == channel);
  assign is_on  = hit && (status[7:4] == 4'h9) && (b[6:0] != 7'd0);
  assign is_off = hit && ((status[7:4] == 4'h8) ||
                          ((status[7:4] == 4'h9) && (b[6:0] == 7'd0)));
  assign is_ano = hit && (status[7:4] == 4'hB) && (d1 == 7'h7B);

  always_comb begin
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!found && (i < int'(cnt)) && (stk[i] == d1)) begin
        found = 1'b1;
        idx   = 2'(i);
      end
    end
    // rem: stack with entry idx squeezed out, everything below moves up
    rem[0] = (idx == 2'd0) ? stk[1] : stk[0];
    rem[1] = (idx <= 2'd1) ? stk[2] : stk[1];
    rem[2] = (idx <= 2'd2) ? stk[3] : stk[2];
    rem[3] = stk[3];
    base   = found ? rem : stk;
    push   = {base[2:0], d1};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stk           <= '0;
      cnt           <= '0;
      note_repeat_q <= 1'b0;
      note_start_q  <= '0;
      velocity_q    <= '0;
    end else if (en) begin
      note_repeat_q <= 1'b0;
      if (is_on) begin
        velocity_q   <= b[6:0];
        note_start_q <= d1;
        if (found && idx == 2'd0) note_repeat_q <= 1'b1;
        else begin
          stk <= push;
          if (!found && cnt != 3'd4) cnt <= cnt + 3'd1;
        end
      end else if (is_off && found) begin
        stk <= rem;
        cnt <= cnt - 3'd1;
        if (cnt > 3'd1) note_start_q <= rem[0];
      end else if (is_ano) begin
        cnt <= '0;
      end
    end
  end

  assign bus.note_on     = (cnt != 3'd0);
  assign bus.note_repeat = note_repeat_q;
  assign bus.note_start  = note_start_q;
  assign bus.velocity    = velocity_q;
endmodule

// File: tb/tb_midi_note_source.sv
// Scoreboard bench: expected voice state queued after each message, compared on the next negedge.
module tb_midi_note_source;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b1;
  logic [3:0] channel = 4'd0;

  midi_note_source_if bus();

  midi_note_source dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .channel (channel),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       on;
    logic       rep;
    logic [6:0] start;
    logic [6:0] vel;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  logic req = 1'b0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  task automatic send(input logic [7:0] v);
    @(posedge clk); #1;
    bus.midi_valid = 1'b1;
    bus.midi_byte  = v;
  endtask

  task automatic msg3(input logic [7:0] a, input logic [7:0] c, input logic [7:0] d);
    send(a); send(c); send(d);
  endtask

  task automatic msg2(input logic [7:0] c, input logic [7:0] d);
    send(c); send(d);
  endtask

  // let the last byte be captured, then queue the state expected after that edge
  task automatic expect_st(input logic on, input logic rep, input logic [6:0] st, input logic [6:0] vl);
    @(posedge clk); #1;
    bus.midi_valid = 1'b0;
    q.push_back('{on: on, rep: rep, start: st, vel: vl});
    req = 1'b1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (req) begin
        req = 1'b0;
        if (q.size() == 0) chk("q_underflow", 8'd1, 8'd0);
        else begin
          e = q.pop_front();
          chk("note_on",     {7'd0, bus.note_on},     {7'd0, e.on});
          chk("note_repeat", {7'd0, bus.note_repeat}, {7'd0, e.rep});
          chk("note_start",  {1'b0, bus.note_start},  {1'b0, e.start});
          chk("velocity",    {1'b0, bus.velocity},    {1'b0, e.vel});
        end
      end
    end
  end

  initial begin
    bus.midi_valid = 1'b0;
    bus.midi_byte  = 8'h00;
    #23 reset = 1'b0;
    expect_st(0, 0, 7'h00, 7'h00);

    // basic note-on and running-status repeat
    msg3(8'h90, 8'h3C, 8'h64);       expect_st(1, 0, 7'h3C, 7'h64);
    msg2(8'h3C, 8'h50);              expect_st(1, 1, 7'h3C, 7'h50);
    expect_st(1, 0, 7'h3C, 7'h50);

    // last-note priority and release back to the previous note
    msg3(8'h90, 8'h3C, 8'h64);       expect_st(1, 1, 7'h3C, 7'h64);
    msg2(8'h40, 8'h64);              expect_st(1, 0, 7'h40, 7'h64);
    msg2(8'h43, 8'h64);              expect_st(1, 0, 7'h43, 7'h64);
    msg3(8'h80, 8'h43, 8'h00);       expect_st(1, 0, 7'h40, 7'h64);
    msg3(8'hB0, 8'h7B, 8'h00);       expect_st(0, 0, 7'h40, 7'h64);

    // re-strike of a buried note moves it to top without a repeat pulse
    msg3(8'h90, 8'h30, 8'h10);       expect_st(1, 0, 7'h30, 7'h10);
    msg2(8'h31, 8'h11);              expect_st(1, 0, 7'h31, 7'h11);
    msg2(8'h30, 8'h12);              expect_st(1, 0, 7'h30, 7'h12);
    msg3(8'h80, 8'h30, 8'h00);       expect_st(1, 0, 7'h31, 7'h12);
    msg2(8'h31, 8'h00);              expect_st(0, 0, 7'h31, 7'h12);

    // overflow drops the oldest entry
    send(8'h90);
    for (int i = 0; i < 5; i++) begin
      msg2(8'h30 + 8'(i), 8'h01 + 8'(i));
      expect_st(1, 0, 7'h30 + 7'(i), 7'h01 + 7'(i));
    end
    send(8'h80);
    for (int i = 0; i < 4; i++) begin
      msg2(8'h34 - 8'(i), 8'h00);
      if (i < 3) expect_st(1, 0, 7'h33 - 7'(i), 7'h05);
      else       expect_st(0, 0, 7'h31, 7'h05);
    end
    msg3(8'h80, 8'h30, 8'h00);       expect_st(0, 0, 7'h31, 7'h05);

    // other channel ignored; realtime byte interleaved is transparent
    msg3(8'h91, 8'h3C, 8'h64);       expect_st(0, 0, 7'h31, 7'h05);
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
    expect_st(1, 0, 7'h3C, 7'h64);

    // system byte kills running status
    send(8'hF0); msg2(8'h3D, 8'h64); expect_st(1, 0, 7'h3C, 7'h64);
    msg3(8'h90, 8'h3D, 8'h64);       expect_st(1, 0, 7'h3D, 7'h64);

    // new status mid-message discards the partial one
    send(8'h90); send(8'h3E);
    msg3(8'h90, 8'h3F, 8'h65);       expect_st(1, 0, 7'h3F, 7'h65);

    // clock enable low: bytes ignored
    en = 1'b0;
    msg3(8'h90, 8'h40, 8'h70);       expect_st(1, 0, 7'h3F, 7'h65);
    en = 1'b1;

    // program change takes one data byte
    send(8'hC0); send(8'h05);
    msg3(8'h90, 8'h41, 8'h66);       expect_st(1, 0, 7'h41, 7'h66);
    msg3(8'hB0, 8'h7B, 8'h00);       expect_st(0, 0, 7'h41, 7'h66);

    // reset between status and data: following data bytes discarded
    send(8'h90);
    @(posedge clk); #1;
    bus.midi_valid = 1'b0;
    #2 reset = 1'b1;
    #3 reset = 1'b0;
    msg2(8'h3C, 8'h64);              expect_st(0, 0, 7'h00, 7'h00);

    repeat (3) @(posedge clk);
    chk("q_drained", 8'(q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
endmodule
